fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised forwarding and load-use hazard unit for the pipelined MIPS datapath. It sits beside the decode/issue stage. Internally it tracks the destination tags of every in-flight instruction in a DEPTH-entry shift register. For NUM_SRC operand ports it issues per-port bypass selects, and it raises Stall when an operand depends on a load whose data is not yet forwardable.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width; register 0 is hardwired zero.
- NUM_SRC, 2, number of operand read ports.
- DEPTH, 3, number of in-flight entries tracked (EX/MEM, MEM/WB, WB/commit).
- LOAD_LAT, 2, entry index from which load data is forwardable; 1 ≤ LOAD_LAT ≤ DEPTH-1.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- Issue_Valid  in  1  an instruction is presented for issue this cycle.
- Issue_Rd  in  REG_ADDR_W  destination register of the issuing instruction.
- Issue_RegWrite  in  1  issuing instruction writes the register file.
- Issue_MemRead  in  1  issuing instruction is a load.
- Flush  in  1  kill the issuing instruction and insert a bubble.
- Src_Addr  in  NUM_SRC*REG_ADDR_W  operand addresses; port p occupies bits [p*REG_ADDR_W +: REG_ADDR_W].
- Src_Used  in  NUM_SRC  port p actually reads its operand; covers ALUSrc-immediate and unused-Rt cases.
- Stall  out  1  load-use hazard; hold the issue stage.
- Fwd_Sel  out  NUM_SRC*SEL_W  per-port bypass select, with SEL_W = clog2(DEPTH+1); 0 = register file, k = result of entry k-1.

## Operation
- Entry record: valid, rd, regwrite, memread. An entry is a producer iff valid && regwrite && rd != 0.
- Shift on every rising edge:
  - entry[k] <= entry[k-1] for k ≥ 1.
  - entry[0] <= issuing record iff Issue_Valid && !Stall && !Flush; otherwise entry[0] <= bubble (valid=0).
  - entry[DEPTH-1] falls off the end.
- Per port p, when Src_Used[p] && Src_Addr[p] != 0:
  - Find the lowest-index (youngest) producer with rd == Src_Addr[p].
  - If that producer is a load (memread) at index k < LOAD_LAT, the port is hazardous.
  - Otherwise Fwd_Sel[p] = k+1.
  - With no match, Fwd_Sel[p] = 0.
- Stall = OR of hazardous ports. While Stall=1 all Fwd_Sel fields are forced to 0.
- Only the youngest match counts. An older non-load producer must never mask a younger load hazard.
- Src_Addr = 0 or Src_Used[p] = 0 gives Fwd_Sel[p] = 0 and no hazard.
- Flush and Stall together: a bubble is inserted, and Flush takes no extra action.
- Reset, including mid-operation: all entries are invalidated immediately and asynchronously, so Stall = 0 and Fwd_Sel = 0 while Rst_n = 0.

## Timing
- Stall and Fwd_Sel are combinational from the current inputs and the registered entries. There are no input-to-output flops.
- A producer issued in cycle N is visible as entry 0 from cycle N+1 and as entry k from cycle N+1+k.
- For a load with consumer issued immediately behind it and LOAD_LAT=2: Stall is high for 2 cycles, then Fwd_Sel = LOAD_LAT+1.
- Stall is deasserted in exactly the cycle the load reaches index LOAD_LAT. There is no extra bubble.

## Configuration
- FWD_STATS_EN defined:
  - Adds ports Stall_Count out 32 and Fwd_Count out 32.
  - Both are saturating counters, reset to 0 and cleared by Rst_n.
  - Stall_Count increments every cycle Stall=1.
  - Fwd_Count increments every cycle any Fwd_Sel field is non-zero.
- FWD_STATS_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Package fwd_pkg holds the entry record typedef, the bubble constant and the SEL_W computation function.
- Sub-module fwd_match: one per operand port, generated NUM_SRC times.
  - Takes the entry array plus one address/used pair.
  - Returns the select and a hazard bit.
  - Implemented as a youngest-first priority encoder.
- Top level holds the shift register, the Stall OR-reduction and the optional counters.

## Test plan
- Reset: hold Rst_n=0 with random inputs -> Stall=0, all Fwd_Sel=0, counters 0. Release, then issue with Src matching nothing -> Fwd_Sel=0.
- ALU chain: issue rd=8 RegWrite, then a consumer with Src0=8 -> Fwd_Sel0=1. One cycle later, with an unrelated instruction between -> Fwd_Sel0=2; after 2 intervening instructions -> 3.
- Load-use: issue load rd=9, then consumer Src1=9 -> Stall=1 for 2 cycles, then Stall=0 with Fwd_Sel1=3.
- Youngest wins: issue rd=5 (ALU), then load rd=5, then consumer Src0=5 -> Stall=1, not Fwd_Sel=2.
- Filters: producers with rd=0, RegWrite=0, or Flush at issue, and consumers with Src_Used=0 -> Fwd_Sel=0, Stall=0.
- Reset mid-stall, and stats: assert Rst_n=0 during a load-use stall -> Stall drops immediately. With FWD_STATS_EN, 2 stall cycles -> Stall_Count=2.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/load-use hazard unit: the in-flight entry
// record, the bubble constant and the bypass-select width helper.
package fwd_pkg;

   // Register tags are stored zero-extended to this width so the record type
   // does not depend on the instantiating module's REG_ADDR_W.
   localparam int FWD_RD_W = 16;

   typedef struct packed {
      logic                valid;
      logic [FWD_RD_W-1:0] rd;
      logic                regwrite;
      logic                memread;
   } fwd_entry_t;

   localparam fwd_entry_t FWD_BUBBLE = '0;

   // Select 0 means register file, k means entry k-1, so DEPTH+1 codes.
   function automatic int fwd_sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand youngest-first match over the in-flight entries. Produces the
// bypass select and a hazard bit when the youngest match is a load that is
// not yet forwardable.
module fwd_match
   import fwd_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 2,
   parameter int SEL_W    = 2
) (
   input  fwd_entry_t          entries [DEPTH],
   input  logic [FWD_RD_W-1:0] addr,
   input  logic                used,
   output logic [SEL_W-1:0]    sel,
   output logic                hazard
);

   // Scan oldest to youngest so the youngest match overwrites older ones;
   // an older ALU producer therefore can never hide a younger load.
   always_comb begin
      sel    = '0;
      hazard = 1'b0;
      if (used && (addr != '0)) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (entries[k].valid && entries[k].regwrite && (entries[k].rd == addr)) begin
               hazard = entries[k].memread && (k < LOAD_LAT);
               sel    = hazard ? '0 : SEL_W'(k + 1);
            end
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit beside the decode/issue stage.
// Tracks destination tags of in-flight instructions in a DEPTH-entry shift
// register and issues per-port bypass selects plus a load-use Stall.
// Optional macro FWD_STATS_EN adds saturating Stall_Count / Fwd_Count.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 3,
   parameter int LOAD_LAT   = 2,
   localparam int SEL_W     = fwd_sel_w(DEPTH)
) (
   input  logic                          Clk,
   input  logic                          Rst_n,
   input  logic                          Issue_Valid,
   input  logic [REG_ADDR_W-1:0]         Issue_Rd,
   input  logic                          Issue_RegWrite,
   input  logic                          Issue_MemRead,
   input  logic                          Flush,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] Src_Addr,
   input  logic [NUM_SRC-1:0]            Src_Used,
   output logic                          Stall,
   output logic [NUM_SRC*SEL_W-1:0]      Fwd_Sel
`ifdef FWD_STATS_EN
   ,
   output logic [31:0]                   Stall_Count,
   output logic [31:0]                   Fwd_Count
`endif
);

   fwd_entry_t             entry_q [DEPTH];
   fwd_entry_t             entry_d [DEPTH];
   logic [SEL_W-1:0]       sel_raw [NUM_SRC];
   logic [NUM_SRC-1:0]     hazard;

   // Next state of the in-flight shift register; a stalled or flushed issue
   // enters as a bubble.
   always_comb begin
      entry_d[0] = FWD_BUBBLE;
      if (Issue_Valid && !Stall && !Flush) begin
         entry_d[0].valid    = 1'b1;
         entry_d[0].rd       = FWD_RD_W'(Issue_Rd);
         entry_d[0].regwrite = Issue_RegWrite;
         entry_d[0].memread  = Issue_MemRead;
      end
      for (int k = 1; k < DEPTH; k++) begin
         entry_d[k] = entry_q[k-1];
      end
   end

   // Entry registers; reset invalidates everything immediately.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            entry_q[k] <= FWD_BUBBLE;
         end
      end else begin
         entry_q <= entry_d;
      end
   end

   for (genvar p = 0; p < NUM_SRC; p++) begin : g_match
      fwd_match #(
         .DEPTH    (DEPTH),
         .LOAD_LAT (LOAD_LAT),
         .SEL_W    (SEL_W)
      ) u_match (
         .entries (entry_q),
         .addr    (FWD_RD_W'(Src_Addr[p*REG_ADDR_W +: REG_ADDR_W])),
         .used    (Src_Used[p]),
         .sel     (sel_raw[p]),
         .hazard  (hazard[p])
      );
   end

   assign Stall = |hazard;

   // Bypass selects are suppressed while the issue stage is held.
   always_comb begin
      Fwd_Sel = '0;
      if (!Stall) begin
         for (int p = 0; p < NUM_SRC; p++) begin
            Fwd_Sel[p*SEL_W +: SEL_W] = sel_raw[p];
         end
      end
   end

`ifdef FWD_STATS_EN
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] fwd_count_q, fwd_count_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   // Saturating event counters for stall and forwarding cycles.
   always_comb begin
      stall_count_d = sat_inc(stall_count_q, Stall);
      fwd_count_d   = sat_inc(fwd_count_q, |Fwd_Sel);
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stall_count_q <= '0;
         fwd_count_q   <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         fwd_count_q   <= fwd_count_d;
      end
   end

   assign Stall_Count = stall_count_q;
   assign Fwd_Count   = fwd_count_q;
`endif

endmodule
